// File: rtl/wb_regfile_if.sv
// wb_regfile_if
// Bundles decode's register-access port of the Y86-64 write-back register
// file: two read ports, the issue handshake, the write-back commit port and
// the per-register pending vector.
//   slave  : the register file (drives read data, stall and pending)
//   master : decode / write-back side (drives indices, issue and commit)
interface wb_regfile_if #(
  parameter int NREGS = 15
);
  logic [3:0]       rd_srcA_i;
  logic [3:0]       rd_srcB_i;
  logic [63:0]      rd_valA_o;
  logic [63:0]      rd_valB_o;
  logic             iss_valid_i;
  logic [3:0]       iss_dstE_i;
  logic [3:0]       iss_dstM_i;
  logic             iss_stall_o;
  logic             wb_valid_i;
  logic [3:0]       wb_dstE_i;
  logic [3:0]       wb_dstM_i;
  logic [63:0]      wb_valE_i;
  logic [63:0]      wb_valM_i;
  logic             wb_cmov_i;
  logic             wb_cnd_i;
  logic [NREGS-1:0] pending_o;

  modport slave (
    input  rd_srcA_i, rd_srcB_i, iss_valid_i, iss_dstE_i, iss_dstM_i,
    input  wb_valid_i, wb_dstE_i, wb_dstM_i, wb_valE_i, wb_valM_i,
    input  wb_cmov_i, wb_cnd_i,
    output rd_valA_o, rd_valB_o, iss_stall_o, pending_o
  );

  modport master (
    output rd_srcA_i, rd_srcB_i, iss_valid_i, iss_dstE_i, iss_dstM_i,
    output wb_valid_i, wb_dstE_i, wb_dstM_i, wb_valE_i, wb_valM_i,
    output wb_cmov_i, wb_cnd_i,
    input  rd_valA_o, rd_valB_o, iss_stall_o, pending_o
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
// Architectural register file r0..r14 for the Y86-64 pipeline with
// same-cycle write bypass and a pending-write scoreboard that stalls decode
// on read-after-write hazards and on pending-counter saturation.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : wb_regfile_if.slave (read ports, issue, write-back, pending)
module wb_regfile #(
  parameter int NREGS = 15,
  parameter int CNT_W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  wb_regfile_if.slave  bus
);

  localparam logic [3:0]       REG_NONE = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [63:0]      regs_q [NREGS];
  logic [63:0]      regs_d [NREGS];
  logic [CNT_W-1:0] cnt_q  [NREGS];
  logic [CNT_W-1:0] cnt_d  [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic             we_e, we_m;
  logic             hazard, overflow, iss_acc;
  logic [NREGS-1:0] ret_hit, iss_hit;
  logic [CNT_W-1:0] eff;
  // Padded to 16 so index 4'hF naturally reads as "not busy / not full".
  logic [15:0]      busy16, full16;
  logic [63:0]      rd_a, rd_b;

  always_comb begin
    we_e = bus.wb_valid_i & (bus.wb_dstE_i != REG_NONE) &
           ~(bus.wb_cmov_i & ~bus.wb_cnd_i);
    we_m = bus.wb_valid_i & (bus.wb_dstM_i != REG_NONE);

    busy16 = '0;
    full16 = '0;
    eff    = '0;
    for (int i = 0; i < NREGS; i++) begin
      // A cmov-suppressed dstE still retires, so use wb_valid_i, not we_e.
      ret_hit[i] = bus.wb_valid_i &
                   ((bus.wb_dstE_i == 4'(i)) | (bus.wb_dstM_i == 4'(i)));
      eff = (ret_hit[i] && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
      busy16[i] = (eff != '0);
      full16[i] = (eff == CNT_MAX);
    end

    hazard   = busy16[bus.rd_srcA_i] | busy16[bus.rd_srcB_i];
    overflow = full16[bus.iss_dstE_i] | full16[bus.iss_dstM_i];
    iss_acc  = rst_n_i & bus.iss_valid_i & ~(hazard | overflow);

    for (int i = 0; i < NREGS; i++) begin
      iss_hit[i] = iss_acc &
                   ((bus.iss_dstE_i == 4'(i)) | (bus.iss_dstM_i == 4'(i)));
      cnt_d[i] = cnt_q[i];
      if (iss_hit[i] && !ret_hit[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!iss_hit[i] && ret_hit[i] && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      pend_d[i] = (cnt_d[i] != '0);

      // M is applied last so it wins a same-register collision (popq %rsp).
      regs_d[i] = regs_q[i];
      if (we_e && bus.wb_dstE_i == 4'(i)) regs_d[i] = bus.wb_valE_i;
      if (we_m && bus.wb_dstM_i == 4'(i)) regs_d[i] = bus.wb_valM_i;
    end
  end

  always_comb begin
    rd_a = '0;
    if (bus.rd_srcA_i != REG_NONE) begin
      if (we_m && bus.wb_dstM_i == bus.rd_srcA_i)      rd_a = bus.wb_valM_i;
      else if (we_e && bus.wb_dstE_i == bus.rd_srcA_i) rd_a = bus.wb_valE_i;
      else if (32'(bus.rd_srcA_i) < NREGS)             rd_a = regs_q[bus.rd_srcA_i];
    end
    rd_b = '0;
    if (bus.rd_srcB_i != REG_NONE) begin
      if (we_m && bus.wb_dstM_i == bus.rd_srcB_i)      rd_b = bus.wb_valM_i;
      else if (we_e && bus.wb_dstE_i == bus.rd_srcB_i) rd_b = bus.wb_valE_i;
      else if (32'(bus.rd_srcB_i) < NREGS)             rd_b = regs_q[bus.rd_srcB_i];
    end
  end

  // Gating with rst_n_i keeps bypassed write-back data off the read ports
  // and the stall low while reset is held.
  assign bus.rd_valA_o   = rst_n_i ? rd_a : '0;
  assign bus.rd_valB_o   = rst_n_i ? rd_b : '0;
  assign bus.iss_stall_o = rst_n_i & bus.iss_valid_i & (hazard | overflow);
  assign bus.pending_o   = pend_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      pend_q <= pend_d;
    end
  end

endmodule
